switch_debounce: RTL and testbench
==================================

Name: switch_debounce

Overview:
- Conditions one raw mechanical switch or push-button input from the board into a clean, glitch-free level.
- Output feeds the single-pulse edge stage that drives the PicoBlaze input port.
- Synchronises the asynchronous pin, then requires DB_CYCLES consecutive stable samples before the output level changes.
- Bounce shorter than the window is rejected entirely.

Parameters:
- N_SYNC, 2, synchroniser flop count (legal range 2..4).
- DB_CYCLES, 1_000_000, stable-sample window in clk cycles (20 ms at 50 MHz); minimum 1.
- CNT_W, 20, counter width; must satisfy 2**CNT_W >= DB_CYCLES.

Ports:
- clk, input, 1, system clock (50 MHz board oscillator).
- rst, input, 1, reset. Synchronous, active-high.
- sw_in, input, 1, raw asynchronous switch/button pin.
- db_level, output, 1, debounced level; drives the downstream edge stage.
- db_busy, output, 1, high while a candidate transition is being qualified.

Behaviour:
- Reset (rst high at a rising clk edge):
  - Synchroniser flops, counter and state clear to 0; state becomes S_ZERO.
  - db_level = 0 and db_busy = 0 from the cycle after that edge.
  - Reset mid-qualification discards the partial count; no output change results.
- Synchroniser: sw_in passes through N_SYNC flops; s_sync is the last flop. Only s_sync is used downstream of the chain.
- FSM, 2-bit, four states:
  - S_ZERO: db_level=0, busy=0. If s_sync=1, go to S_WAIT1 and load cnt=0. Otherwise stay.
  - S_WAIT1: db_level=0, busy=1.
    - If s_sync=0: go to S_ZERO (bounce rejected).
    - Else if cnt==DB_CYCLES-1: go to S_ONE.
    - Else cnt <= cnt+1.
  - S_ONE: db_level=1, busy=0. If s_sync=0, go to S_WAIT0 and load cnt=0.
  - S_WAIT0: db_level=1, busy=1. Symmetric to S_WAIT1: s_sync=1 returns to S_ONE; cnt==DB_CYCLES-1 goes to S_ZERO.
- Outputs are Moore, decoded from the state register only. No glitches.
- Latency:
  - Number clk edges from the first edge that samples the new sw_in value as edge 1.
  - db_level changes after edge N_SYNC+DB_CYCLES+1, provided sw_in is held stable throughout.
- Counter:
  - Unsigned, saturating logic not required; it never exceeds DB_CYCLES-1.
  - Cleared on every entry to a WAIT state.
- Any single-sample disagreement inside a WAIT state aborts qualification. Re-qualification then restarts from 0 on the next opposite sample.
- DB_CYCLES=1: WAIT state lasts exactly one cycle.

Optional Feature:
- Macro: SWITCH_DEBOUNCE_ACTIVE_LOW_EN.
- Defined: sw_in is inverted before the synchroniser (pulled-up buttons). Synchroniser flops reset to 1, so a released button (pin high) yields db_level=0 with no spurious qualification after reset.
- Undefined: sw_in is used as-is; flops reset to 0.

Decomposition:
- Shared package debounce_pkg:
  - State encodings S_ZERO=2'b00, S_WAIT1=2'b01, S_ONE=2'b11, S_WAIT0=2'b10.
  - Default constants CLK_HZ=50_000_000 and DB_MS=20.
- One sub-module: db_sync (parameterised N_SYNC flop chain with reset value input), reused by other pin inputs.

Test Plan (N_SYNC=2, DB_CYCLES=4, CNT_W=3):
- Reset then idle: assert rst 2 cycles with sw_in=0 -> db_level=0 and db_busy=0, held for 20 cycles.
- Clean press: sw_in 0->1 before edge 1, held -> db_busy=1 after edge 3; db_level=1 after edge 7; db_busy=0 after edge 7.
- Bounce rejection: sw_in pattern 1,1,0,1,1,0 one sample per cycle, then 0 -> db_level stays 0; db_busy returns to 0.
- Clean release: from db_level=1, sw_in 1->0 held -> db_level=0 after edge 7, mirror of the press case.
- Reset mid-qualification: rst asserted at edge 5 of a press -> db_level=0, state S_ZERO. Requalification takes the full 7 edges after rst deasserts.
- ACTIVE_LOW_EN build: sw_in held 1 through reset -> db_level=0; sw_in 1->0 held -> db_level=1 after edge 7.

Source files
------------

// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
//
// Shared definitions for the switch/button conditioning path.
//   - state_t       : debouncer FSM encoding. Every legal transition flips
//                     exactly one bit, so the decoded outputs are glitch-free.
//   - CLK_HZ, DB_MS : board defaults (50 MHz oscillator, 20 ms window).
//   - DEF_DB_CYCLES : default qualification window in clk cycles.
//   - state_level() / state_busy() : Moore output decode from a state value.
// -----------------------------------------------------------------------------
package debounce_pkg;

  localparam int CLK_HZ        = 50_000_000;
  localparam int DB_MS         = 20;
  localparam int DEF_DB_CYCLES = (CLK_HZ / 1000) * DB_MS;

  // Bit 1 carries the debounced level and bit 0 marks the "other half" of
  // the ring, so WAIT states are exactly the ones whose bits differ.
  typedef enum logic [1:0] {
    S_ZERO  = 2'b00,
    S_WAIT1 = 2'b01,
    S_ONE   = 2'b11,
    S_WAIT0 = 2'b10
  } state_t;

  function automatic logic state_level(input state_t s);
    return s[1];
  endfunction

  function automatic logic state_busy(input state_t s);
    return s[1] ^ s[0];
  endfunction

endpackage : debounce_pkg

// File: rtl/db_sync.sv
// -----------------------------------------------------------------------------
// db_sync
//
// N_SYNC-flop synchroniser for one asynchronous pin. The reset value is an
// input so pins with pull-ups can power up in their idle level.
//
// Ports:
//   clk     : system clock
//   rst     : synchronous, active-high reset
//   rst_val : value every flop takes on reset
//   d       : asynchronous input
//   q       : synchronised output (last flop of the chain)
//
// Parameters:
//   N_SYNC  : flop count, 2..4
// -----------------------------------------------------------------------------
module db_sync #(
  parameter int N_SYNC = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rst_val,
  input  logic d,
  output logic q
);

  logic [N_SYNC-1:0] ff;

  // NOTE: reset is sampled on the clock edge here (synchronous), so rst
  // stays out of the sensitivity list and must itself be synchronous.
  always_ff @(posedge clk) begin
    if (rst) begin
      ff <= {N_SYNC{rst_val}};
    end else begin
      // NOTE: non-blocking assignment so each flop captures its
      // neighbour's pre-edge value; blocking would collapse the chain.
      ff <= {ff[N_SYNC-2:0], d};
    end
  end

  assign q = ff[N_SYNC-1];

endmodule : db_sync

// File: rtl/switch_debounce.sv
// -----------------------------------------------------------------------------
// switch_debounce
//
// Conditions one raw mechanical switch/button into a clean level for the
// downstream single-pulse edge stage. The pin is synchronised, then the
// output only changes after DB_CYCLES+1 consecutive samples disagreeing with
// the current level; any agreeing sample in between aborts qualification.
//
// Ports:
//   clk      : system clock (50 MHz)
//   rst      : synchronous, active-high reset
//   sw_in    : raw asynchronous switch/button pin
//   db_level : debounced level
//   db_busy  : high while a candidate transition is being qualified
//
// Parameters:
//   N_SYNC    : synchroniser depth, 2..4
//   DB_CYCLES : stable-sample window in clk cycles, >= 1
//   CNT_W     : counter width, 2**CNT_W >= DB_CYCLES
//
// Build option:
//   SWITCH_DEBOUNCE_ACTIVE_LOW_EN : pin is active low (pulled-up button).
//     The chain runs on the raw pin, resets to 1 (released) and its output
//     is inverted. Timing matches inverting ahead of the chain, but the
//     chain already holds the idle level out of reset, so the FSM never
//     sees a phantom press.
//
// Latency: with sw_in held, db_level changes after edge N_SYNC+DB_CYCLES+1,
// counting the first edge that samples the new pin value as edge 1.
// -----------------------------------------------------------------------------
module switch_debounce
  import debounce_pkg::*;
#(
  parameter int N_SYNC    = 2,
  parameter int DB_CYCLES = DEF_DB_CYCLES,
  parameter int CNT_W     = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_in,
  output logic db_level,
  output logic db_busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic sync_q;
  logic s_sync;

`ifdef SWITCH_DEBOUNCE_ACTIVE_LOW_EN
  localparam logic SYNC_RST_VAL = 1'b1;
`else
  localparam logic SYNC_RST_VAL = 1'b0;
`endif

  db_sync #(
    .N_SYNC (N_SYNC)
  ) u_sync (
    .clk     (clk),
    .rst     (rst),
    .rst_val (SYNC_RST_VAL),
    .d       (sw_in),
    .q       (sync_q)
  );

`ifdef SWITCH_DEBOUNCE_ACTIVE_LOW_EN
  assign s_sync = ~sync_q;
`else
  assign s_sync = sync_q;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_ZERO;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Counter is cleared on every WAIT entry and only advances while the
  // sample keeps disagreeing with the level, so it tops out at CNT_LAST.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs; a missing
    // branch would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_ZERO: begin
        if (s_sync) begin
          state_d = S_WAIT1;
          cnt_d   = '0;
        end
      end
      S_WAIT1: begin
        if (!s_sync) begin
          state_d = S_ZERO;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_ONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_ONE: begin
        if (!s_sync) begin
          state_d = S_WAIT0;
          cnt_d   = '0;
        end
      end
      S_WAIT0: begin
        if (s_sync) begin
          state_d = S_ONE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_ZERO;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_ZERO;
        cnt_d   = '0;
      end
    endcase
  end

  // Moore decode straight off the state register; single-bit state steps
  // keep both outputs free of decode glitches.
  assign db_level = state_level(state_q);
  assign db_busy  = state_busy(state_q);

endmodule : switch_debounce

// File: tb/tb_switch_debounce.sv
// -----------------------------------------------------------------------------
// tb_switch_debounce
//
// Drives the debouncer with directed scenarios and randomized bounce runs,
// comparing db_level/db_busy every cycle with a reference model that tracks
// the delayed pin sample and a run length of disagreeing samples.
// -----------------------------------------------------------------------------
module tb_switch_debounce;
  import debounce_pkg::*;

  localparam int N_SYNC    = 2;
  localparam int DB_CYCLES = 4;
  localparam int CNT_W     = 3;
  localparam int LATENCY   = N_SYNC + DB_CYCLES + 1;

`ifdef SWITCH_DEBOUNCE_ACTIVE_LOW_EN
  localparam logic PIN_INV = 1'b1;
`else
  localparam logic PIN_INV = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic sw_in;
  logic db_level;
  logic db_busy;

  always #5 clk = ~clk;

  switch_debounce #(
    .N_SYNC    (N_SYNC),
    .DB_CYCLES (DB_CYCLES),
    .CNT_W     (CNT_W)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .sw_in    (sw_in),
    .db_level (db_level),
    .db_busy  (db_busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model, in the "pressed" domain (1 = switch active).
  logic m_pipe [N_SYNC];
  logic m_level;
  int   m_run;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // The level flips once DB_CYCLES+1 consecutive synchronised samples
  // disagree with it; busy means a disagreeing run is in progress.
  task automatic model_edge(input logic p, input logic r);
    logic s;
    if (r) begin
      for (int i = 0; i < N_SYNC; i++) m_pipe[i] = 1'b0;
      m_level = 1'b0;
      m_run   = 0;
    end else begin
      s = m_pipe[N_SYNC-1];
      for (int i = N_SYNC - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
      m_pipe[0] = p;
      if (s != m_level) begin
        m_run++;
        if (m_run == DB_CYCLES + 1) begin
          m_level = ~m_level;
          m_run   = 0;
        end
      end else begin
        m_run = 0;
      end
    end
  endtask

  task automatic cycle(input logic p, input logic r);
    sw_in = p ^ PIN_INV;
    rst   = r;
    @(posedge clk);
    model_edge(p, r);
    @(negedge clk);
    check("db_level", int'(db_level), int'(m_level));
    check("db_busy", int'(db_busy), (m_run > 0) ? 1 : 0);
  endtask

  // Holds the pin at p and counts edges until db_level follows (bounded).
  task automatic measure(input string tag, input logic p);
    int edges = 0;
    for (int k = 1; k <= 20 && edges == 0; k++) begin
      cycle(p, 1'b0);
      if (k == N_SYNC)     check({tag, "_busy_pre"}, int'(db_busy), 0);
      if (k == N_SYNC + 1) check({tag, "_busy_on"},  int'(db_busy), 1);
      if (db_level == p) edges = k;
    end
    check({tag, "_latency"}, edges, LATENCY);
  endtask

  initial begin
    logic [5:0] bounce;
    logic       p;
    int         run_len;

    for (int i = 0; i < N_SYNC; i++) m_pipe[i] = 1'b0;
    m_level = 1'b0;
    m_run   = 0;
    rst     = 1'b1;
    sw_in   = PIN_INV;

    // Reset then idle.
    repeat (2)  cycle(1'b0, 1'b1);
    check("reset_level", int'(db_level), 0);
    check("reset_state", int'(u_dut.state_q), int'(S_ZERO));
    repeat (20) cycle(1'b0, 1'b0);

    // Clean press and release.
    measure("press", 1'b1);
    repeat (5) cycle(1'b1, 1'b0);
    measure("release", 1'b0);
    repeat (5) cycle(1'b0, 1'b0);

    // Bounce shorter than the window.
    bounce = 6'b011011;
    for (int i = 0; i < 6; i++) cycle(bounce[i], 1'b0);
    repeat (10) cycle(1'b0, 1'b0);
    check("bounce_level", int'(db_level), 0);
    check("bounce_busy", int'(db_busy), 0);

    // Reset at edge 5 of a press, then full requalification.
    repeat (4) cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b1);
    check("midrst_state", int'(u_dut.state_q), int'(S_ZERO));
    check("midrst_level", int'(db_level), 0);
    measure("requal", 1'b1);
    repeat (3) cycle(1'b1, 1'b0);
    measure("requal_release", 1'b0);

    // Randomized bounce runs around the window length, with rare resets.
    p = 1'b0;
    for (int n = 0; n < 600; n++) begin
      p       = ~p;
      run_len = $urandom_range(1, 2 * (DB_CYCLES + 1));
      for (int k = 0; k < run_len; k++) begin
        cycle(p, ($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0);
      end
    end
    repeat (LATENCY + 2) cycle(p, 1'b0);
    check("final_level", int'(db_level), int'(p));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_switch_debounce
